// File: rtl/combo_lock_pkg.sv
// Shared types and defaults for the combination-lock controller.
package combo_lock_pkg;
  localparam int CL_DIGIT_W    = 4;
  localparam int CL_NUM_DIGITS = 4;
  localparam logic [CL_NUM_DIGITS*CL_DIGIT_W-1:0] CL_DEFAULT_COMBO = 16'h1234;

  typedef logic [CL_DIGIT_W-1:0] digit_t;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } state_e;
endpackage

// File: rtl/combo_digit_counter.sv
// Wrapping up/down digit counter with its own button edge detection.
module combo_digit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         i_up,
  input  logic         i_down,
  input  logic         i_en,
  input  logic         i_zero,
  output logic [W-1:0] o_cnt
);
  logic         r_up_prev, r_dn_prev;
  logic [W-1:0] r_cnt;
  logic         w_up, w_dn;

  // prev registers track the buttons even while disabled so a held button never acts
  assign w_up = i_up & ~r_up_prev & i_en;
  assign w_dn = i_down & ~r_dn_prev & i_en;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_up_prev <= 1'b0;
      r_dn_prev <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_up_prev <= i_up;
      r_dn_prev <= i_down;
      if (i_zero)            r_cnt <= '0;
      else if (w_up & ~w_dn) r_cnt <= r_cnt + 1'b1;
      else if (w_dn & ~w_up) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencer: digit entry, check, open and timed lockout.
// Define COMBO_LOCK_PROG_EN to add the prog input and a reprogrammable combination.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int NUM_DIGITS     = CL_NUM_DIGITS,
  parameter int DIGIT_W        = CL_DIGIT_W,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] COMBO = CL_DEFAULT_COMBO,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               up,
  input  logic               down,
  input  logic               enter,
  input  logic               clear,
`ifdef COMBO_LOCK_PROG_EN
  input  logic               prog,
`endif
  output logic [DIGIT_W-1:0] digitOut,
  output logic [IDX_W-1:0]   digitIdx,
  output logic               unlocked,
  output logic               lockedOut,
  output logic               errorPulse
);
  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  state_e              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CODE_W-1:0]   r_code;
  logic [FAIL_W-1:0]   r_fail;
  logic [TMR_W-1:0]    r_tmr;
  logic                r_err;
  logic                r_ent_prev, r_clr_prev;
  logic [DIGIT_W-1:0]  w_cnt;
  logic [CODE_W-1:0]   w_code_next, w_combo;
  logic                w_enter, w_clear, w_prog_go, w_last, w_act, w_cnt_zero;

  assign w_enter = enter & ~r_ent_prev;
  assign w_clear = clear & ~r_clr_prev;
  assign w_last  = (r_idx == IDX_LAST);

`ifdef COMBO_LOCK_PROG_EN
  logic              r_prog_prev;
  logic [CODE_W-1:0] r_combo;

  assign w_prog_go = prog & ~r_prog_prev & (r_state == ST_OPEN);
  assign w_combo   = r_combo;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_prog_prev <= 1'b0;
      r_combo     <= COMBO;
    end else begin
      r_prog_prev <= prog;
      if (r_state == ST_PROG && !w_clear && w_enter && w_last) r_combo <= w_code_next;
    end
  end
`else
  assign w_prog_go = 1'b0;
  assign w_combo   = COMBO;
`endif

  // Counter moves only where the buttons are live; any accepted action or CHECK exit clears it
  assign w_act      = (r_state == ST_ENTRY) | (r_state == ST_OPEN) | (r_state == ST_PROG);
  assign w_cnt_zero = (r_state == ST_CHECK) | (w_act & (w_clear | w_enter | w_prog_go));

  combo_digit_counter #(.W(DIGIT_W)) u_cnt (
    .clk    (clk),
    .rstN   (rstN),
    .i_up   (up),
    .i_down (down),
    .i_en   (w_act),
    .i_zero (w_cnt_zero),
    .o_cnt  (w_cnt)
  );

  // Slot 0 lives in the most significant digit, matching COMBO
  always_comb begin
    w_code_next = r_code;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_idx == IDX_W'(i)) w_code_next[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = w_cnt;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= ST_ENTRY;
      r_idx      <= '0;
      r_code     <= '0;
      r_fail     <= '0;
      r_tmr      <= '0;
      r_err      <= 1'b0;
      r_ent_prev <= 1'b0;
      r_clr_prev <= 1'b0;
    end else begin
      r_ent_prev <= enter;
      r_clr_prev <= clear;
      r_err      <= 1'b0;
      case (r_state)
        ST_ENTRY: begin
          if (w_clear) begin
            r_idx  <= '0;
            r_code <= '0;
          end else if (w_enter) begin
            r_code <= w_code_next;
            if (w_last) r_state <= ST_CHECK;
            else        r_idx   <= r_idx + 1'b1;
          end
        end
        ST_CHECK: begin
          r_idx <= '0;
          if (r_code == w_combo) begin
            r_state <= ST_OPEN;
            r_fail  <= '0;
          end else if (r_fail == FAIL_LAST) begin
            r_state <= ST_LOCKOUT;
            r_tmr   <= TMR_LOAD;
          end else begin
            r_state <= ST_ENTRY;
            r_fail  <= r_fail + 1'b1;
            r_err   <= 1'b1;
          end
        end
        ST_OPEN: begin
          if (w_clear | w_enter) r_state <= ST_ENTRY;
`ifdef COMBO_LOCK_PROG_EN
          else if (w_prog_go) begin
            r_state <= ST_PROG;
            r_code  <= '0;
          end
`endif
        end
        ST_LOCKOUT: begin
          if (r_tmr == '0) begin
            r_state <= ST_ENTRY;
            r_fail  <= '0;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
`ifdef COMBO_LOCK_PROG_EN
        ST_PROG: begin
          if (w_clear) begin
            r_state <= ST_OPEN;
            r_idx   <= '0;
          end else if (w_enter) begin
            r_code <= w_code_next;
            if (w_last) begin
              r_state <= ST_OPEN;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
`endif
        default: r_state <= ST_ENTRY;
      endcase
    end
  end

  assign digitOut   = w_cnt;
  assign digitIdx   = r_idx;
  assign unlocked   = (r_state == ST_OPEN);
  assign lockedOut  = (r_state == ST_LOCKOUT);
  assign errorPulse = r_err;
endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Self-checking bench for combo_lock_ctrl against a transaction-level lock model.
`timescale 1ns/1ps
module tb_combo_lock_ctrl;
  localparam int ND = 4, DW = 4, MAXF = 3, LCY = 1000;

  logic clk = 1'b0, rstN = 1'b1, up = 1'b0, down = 1'b0, enter = 1'b0, clear = 1'b0;
`ifdef COMBO_LOCK_PROG_EN
  logic prog = 1'b0;
`endif
  logic [DW-1:0] digitOut;
  logic [1:0]    digitIdx;
  logic          unlocked, lockedOut, errorPulse;

  int n_checks = 0, n_fail = 0, n_err_seen = 0, m_err_exp = 0;
  int m_combo[ND] = '{1, 2, 3, 4};
  int m_fail = 0, m_digit = 0, m_idx = 0;

  combo_lock_ctrl #(.NUM_DIGITS(ND), .DIGIT_W(DW), .COMBO(16'h1234), .MAX_FAIL(MAXF),
                    .LOCKOUT_CYCLES(LCY)) dut (
    .clk(clk), .rstN(rstN), .up(up), .down(down), .enter(enter), .clear(clear),
`ifdef COMBO_LOCK_PROG_EN
    .prog(prog),
`endif
    .digitOut(digitOut), .digitIdx(digitIdx), .unlocked(unlocked),
    .lockedOut(lockedOut), .errorPulse(errorPulse)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rstN && errorPulse === 1'b1) n_err_seen++;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic press(input bit u, input bit d, input bit e, input bit c);
    up = u; down = d; enter = e; clear = c;
    tick;
    up = 0; down = 0; enter = 0; clear = 0;
    tick;
  endtask

  task automatic model_clear;
    m_digit = 0; m_idx = 0;
  endtask

  function automatic bit same_code(input int a[ND], input int b[ND]);
    for (int k = 0; k < ND; k++) if (a[k] != b[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_digit(input int d, input bit use_up);
    int nu;
    nu = (d - m_digit + 16) % 16;
    if (use_up || $urandom_range(0, 1) == 1) repeat (nu) press(1, 0, 0, 0);
    else repeat ((16 - nu) % 16) press(0, 1, 0, 0);
    m_digit = d;
    n_checks++;
    if (digitOut !== 4'(m_digit)) begin
      n_fail++; $display("FAIL set_digit: digitOut=%0d expected %0d", digitOut, m_digit);
    end
  endtask

  task automatic enter_digit(input int d, input bit use_up);
    set_digit(d, use_up);
    press(0, 0, 1, 0);
    m_idx++; m_digit = 0;
    n_checks++;
    if (int'(digitIdx) !== m_idx || digitOut !== 4'd0) begin
      n_fail++; $display("FAIL enter_digit: idx=%0d digit=%0d expected idx %0d digit 0", digitIdx, digitOut, m_idx);
    end
  endtask

  task automatic enter_code(input int ds[ND], input bit use_up, input bit prog_mode);
    bit match, exp_u, exp_l, exp_e;
    for (int k = 0; k < ND - 1; k++) enter_digit(ds[k], use_up);
    set_digit(ds[ND-1], use_up);
    enter = 1; tick; enter = 0;
    if (prog_mode) begin
      tick;
      n_checks++;
      if (unlocked !== 1'b1 || int'(digitIdx) !== 0) begin
        n_fail++; $display("FAIL prog_done: unlocked=%0d idx=%0d expected 1 and 0", unlocked, digitIdx);
      end
      for (int k = 0; k < ND; k++) m_combo[k] = ds[k];
    end else begin
      n_checks++;
      if ({unlocked, lockedOut, errorPulse} !== 3'b000) begin
        n_fail++; $display("FAIL check_cycle: status=%b expected 000", {unlocked, lockedOut, errorPulse});
      end
      tick;
      match = same_code(ds, m_combo);
      exp_u = match;
      exp_l = !match && (m_fail + 1 == MAXF);
      exp_e = !match && !exp_l;
      n_checks++;
      if ({unlocked, lockedOut, errorPulse} !== {exp_u, exp_l, exp_e}) begin
        n_fail++; $display("FAIL outcome: status=%b expected %b", {unlocked, lockedOut, errorPulse}, {exp_u, exp_l, exp_e});
      end
      n_checks++;
      if (digitIdx !== 2'd0 || digitOut !== 4'd0) begin
        n_fail++; $display("FAIL check_exit_zero: idx=%0d digit=%0d expected 0 0", digitIdx, digitOut);
      end
      if (exp_u) m_fail = 0;
      if (exp_e) begin
        m_fail++; m_err_exp++;
        tick;
        n_checks++;
        if (errorPulse !== 1'b0) begin
          n_fail++; $display("FAIL err_width: errorPulse=%0d expected 0", errorPulse);
        end
      end
    end
    model_clear;
  endtask

  task automatic wrong_code;
    int w[ND];
    for (int k = 0; k < ND; k++) w[k] = $urandom_range(0, 15);
    if (same_code(w, m_combo)) w[0] = (w[0] + 1) % 16;
    enter_code(w, 1'b0, 1'b0);
  endtask

  task automatic relock;
    press(0, 0, 0, 1);
    model_clear;
    n_checks++;
    if (unlocked !== 1'b0) begin
      n_fail++; $display("FAIL relock: unlocked=%0d expected 0", unlocked);
    end
  endtask

  task automatic test_reset;
    #2 rstN = 0; #1;
    n_checks++;
    if ({digitOut, digitIdx, unlocked, lockedOut, errorPulse} !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0", {digitOut, digitIdx, unlocked, lockedOut, errorPulse});
    end
    tick; tick; rstN = 1; tick;
    n_checks++;
    if ({digitOut, digitIdx, unlocked, lockedOut, errorPulse} !== 9'd0) begin
      n_fail++; $display("FAIL post_reset: got %b expected 0", {digitOut, digitIdx, unlocked, lockedOut, errorPulse});
    end
  endtask

  task automatic test_correct_code;
    enter_code(m_combo, 1'b1, 1'b0);
    n_checks++;
    if (n_err_seen !== 0) begin
      n_fail++; $display("FAIL correct_no_error: errorPulse cycles=%0d expected 0", n_err_seen);
    end
    relock;
  endtask

  task automatic test_wrap;
    int u, d;
    press(0, 1, 0, 0);
    n_checks++;
    if (digitOut !== 4'd15) begin n_fail++; $display("FAIL wrap_down: got %0d expected 15", digitOut); end
    press(1, 0, 0, 0);
    n_checks++;
    if (digitOut !== 4'd0) begin n_fail++; $display("FAIL wrap_up: got %0d expected 0", digitOut); end
    set_digit(5, 1'b1);
    press(1, 1, 0, 0);
    n_checks++;
    if (digitOut !== 4'd5) begin n_fail++; $display("FAIL up_down_cancel: got %0d expected 5", digitOut); end
    up = 1; repeat (3) tick; up = 0; tick;
    m_digit = 6;
    n_checks++;
    if (digitOut !== 4'd6) begin n_fail++; $display("FAIL held_up_once: got %0d expected 6", digitOut); end
    for (int i = 0; i < 24; i++) begin
      u = $urandom_range(0, 1); d = $urandom_range(0, 1);
      press(u[0], d[0], 0, 0);
      m_digit = (m_digit + u - d + 16) % 16;
      n_checks++;
      if (digitOut !== 4'(m_digit)) begin
        n_fail++; $display("FAIL random_updown: got %0d expected %0d", digitOut, m_digit);
      end
    end
    press(0, 0, 0, 1);
    model_clear;
  endtask

  task automatic test_clear;
    enter_digit(1, 1'b0);
    enter_digit(2, 1'b0);
    press(0, 0, 0, 1);
    model_clear;
    n_checks++;
    if (digitIdx !== 2'd0 || digitOut !== 4'd0) begin
      n_fail++; $display("FAIL clear_entry: idx=%0d digit=%0d expected 0 0", digitIdx, digitOut);
    end
    enter_digit(7, 1'b0);
    set_digit(9, 1'b0);
    press(0, 0, 1, 1);
    model_clear;
    n_checks++;
    if (digitIdx !== 2'd0 || digitOut !== 4'd0) begin
      n_fail++; $display("FAIL clear_over_enter: idx=%0d digit=%0d expected 0 0", digitIdx, digitOut);
    end
    enter_code(m_combo, 1'b0, 1'b0);
    relock;
  endtask

  task automatic test_lockout;
    int cnt, zeros[ND];
    for (int k = 0; k < ND; k++) zeros[k] = 0;
    enter_code(zeros, 1'b0, 1'b0);
    wrong_code();
    wrong_code();
    cnt = 0;
    while (lockedOut === 1'b1 && cnt < 2 * LCY) begin
      cnt++;
      up = 1'($urandom_range(0, 1)); down = 1'($urandom_range(0, 1));
      enter = 1'($urandom_range(0, 1)); clear = 1'($urandom_range(0, 1));
      tick;
    end
    tick;
    up = 0; down = 0; enter = 0; clear = 0;
    tick;
    m_fail = 0;
    n_checks++;
    if (cnt !== LCY) begin n_fail++; $display("FAIL lockout_len: got %0d cycles expected %0d", cnt, LCY); end
    n_checks++;
    if ({digitOut, digitIdx, unlocked, lockedOut} !== 8'd0) begin
      n_fail++; $display("FAIL lockout_exit: got %b expected 0", {digitOut, digitIdx, unlocked, lockedOut});
    end
    enter_code(m_combo, 1'b0, 1'b0);
    relock;
  endtask

  task automatic test_reset_mid;
    repeat (MAXF) wrong_code();
    repeat (50) tick;
    #2 rstN = 0; #1;
    n_checks++;
    if ({digitOut, digitIdx, unlocked, lockedOut, errorPulse} !== 9'd0) begin
      n_fail++; $display("FAIL reset_mid: got %b expected 0", {digitOut, digitIdx, unlocked, lockedOut, errorPulse});
    end
    tick; rstN = 1; tick;
    m_fail = 0; model_clear;
    for (int k = 0; k < ND; k++) m_combo[k] = k + 1;
    wrong_code();
    enter_code(m_combo, 1'b0, 1'b0);
    relock;
  endtask

`ifdef COMBO_LOCK_PROG_EN
  task automatic press_prog;
    prog = 1; tick; prog = 0; tick;
  endtask

  task automatic test_prog;
    int old_c[ND], new_c[ND];
    old_c = m_combo;
    new_c = '{5, 6, 7, 8};
    enter_code(m_combo, 1'b0, 1'b0);
    press_prog;
    model_clear;
    enter_code(new_c, 1'b0, 1'b1);
    relock;
    enter_code(old_c, 1'b0, 1'b0);
    enter_code(new_c, 1'b0, 1'b0);
    press_prog;
    model_clear;
    enter_digit(9, 1'b0);
    press(0, 0, 0, 1);
    model_clear;
    n_checks++;
    if (unlocked !== 1'b1) begin n_fail++; $display("FAIL prog_clear: unlocked=%0d expected 1", unlocked); end
    relock;
    enter_code(new_c, 1'b0, 1'b0);
    relock;
  endtask
`endif

  initial begin
    test_reset;
    test_correct_code;
    test_wrap;
    test_clear;
    test_lockout;
    test_reset_mid;
`ifdef COMBO_LOCK_PROG_EN
    test_prog;
`endif
    tick;
    n_checks++;
    if (n_err_seen !== m_err_exp) begin
      n_fail++; $display("FAIL error_pulse_total: got %0d cycles expected %0d", n_err_seen, m_err_exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/combo_lock_ctrl.md
# combo_lock_ctrl

Sequencing controller for the combination lock. Owns the shared 4-bit digit up/down counter, turns level-sensitive `up`/`down`/`enter`/`clear` button inputs into single-cycle actions, and collects `NUM_DIGITS` entered digits. It compares them against the stored combination and drives unlock, error and lockout status. Sits between the debounced button front-end and the display/actuator logic.

## Interface
- `NUM_DIGITS`, 4: digits per combination.
- `DIGIT_W`, 4: digit width in bits; digits wrap modulo 2^DIGIT_W.
- `COMBO`, 16'h1234: reset combination, digit 0 in the MS nibble; width NUM_DIGITS*DIGIT_W.
- `MAX_FAIL`, 3: consecutive wrong attempts that trigger lockout.
- `LOCKOUT_CYCLES`, 1000: lockout duration in clk cycles.
- `clk` in 1: system clock, rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `up` in 1: increment button level, synchronous and debounced upstream.
- `down` in 1: decrement button level.
- `enter` in 1: accept current digit.
- `clear` in 1: abandon entry, or relock from OPEN.
- `prog` in 1: program request. Present only with COMBO_LOCK_PROG_EN.
- `digitOut` out DIGIT_W: current counter value.
- `digitIdx` out clog2(NUM_DIGITS): index of the digit being entered.
- `unlocked` out 1: high in OPEN.
- `lockedOut` out 1: high in LOCKOUT.
- `errorPulse` out 1: one-cycle pulse on a wrong attempt that does not cause lockout.

## Operation
- Each button input has a previous-sample register. Action = input & ~prev, so a held button acts once.
- Priority within one cycle: clear > enter > up/down.
- `up` and `down` actions in the same cycle cancel each other: no change.
- Counter arithmetic is modulo 2^DIGIT_W: 15+1 → 0, 0−1 → 15.
- States:
  - **ENTRY** (reset state)
    - up/down modify the counter.
    - enter stores the counter into slot `digitIdx`, increments `digitIdx`, and zeroes the counter.
    - On the enter for slot NUM_DIGITS−1 → CHECK.
    - clear zeroes the counter and `digitIdx`, discards stored digits; fail count is unchanged.
  - **CHECK** (exactly 1 cycle; inputs ignored)
    - Match → OPEN and fail count cleared.
    - Mismatch with fail count+1 = MAX_FAIL → LOCKOUT; lockout timer loaded.
    - Otherwise mismatch → ENTRY, fail count incremented, `errorPulse` asserted.
    - `digitIdx` and the counter are zeroed on the CHECK exit.
  - **OPEN**
    - enter or clear → ENTRY (relock).
    - up/down still move the counter.
  - **LOCKOUT**
    - All button inputs ignored. Prev registers keep updating, so a button held through the exit does not act.
    - Timer counts down to 0, then → ENTRY with fail count cleared.
- A reset mid-operation discards everything. The combination register reloads COMBO.

## Timing
- Reset values:
  - `digitOut`=0, `digitIdx`=0, `unlocked`=0, `lockedOut`=0, `errorPulse`=0.
  - State ENTRY, fail count 0, prev registers 0.
- Counter update: `digitOut` changes at the first rising clk edge that samples the button high.
- Final enter sampled at edge E:
  - CHECK during cycle E..E+1.
  - `unlocked`, `lockedOut` or `errorPulse` becomes valid after edge E+1.
- `errorPulse` is exactly one cycle wide.
- `lockedOut` stays high for exactly LOCKOUT_CYCLES cycles.

## Configuration
- `COMBO_LOCK_PROG_EN` defined:
  - `prog` port exists; the combination is a register.
  - In OPEN, a `prog` rising edge → state PROG.
  - PROG runs ENTRY-style digit entry.
  - On the final enter, the register is overwritten and the state returns to OPEN.
  - clear in PROG → OPEN with the register unchanged.
- Not defined: no `prog` port and no PROG state; the combination is the constant COMBO.

## Structure
- Package `combo_lock_pkg`:
  - state enum (ENTRY, CHECK, OPEN, LOCKOUT, PROG).
  - DIGIT_W-based digit typedef.
  - default COMBO constant.
- Sub-module `combo_digit_counter`:
  - Wrapping up/down counter with synchronous zero input and async active-low reset.
  - Instantiated once.
  - Performs the edge detection and up/down cancellation internally.

## Test plan
- Correct code:
  - Reset, then per digit: pulse up 1/2/3/4 times followed by enter (digits 1,2,3,4).
  - Expect `digitIdx` 0→1→2→3→0.
  - Expect `unlocked`=1 two edges after the final enter sample; `errorPulse` never asserts.
- Wrap-around:
  - down once from 0 → `digitOut`=15; then up → 0.
  - up and down rising in the same cycle → no change.
- Three wrong codes (0,0,0,0):
  - `errorPulse` on attempts 1 and 2.
  - Attempt 3 gives `lockedOut`=1 for 1000 cycles with buttons ignored.
  - Then the correct code unlocks.
- Clear:
  - Enter 1,2 then clear → `digitIdx`=0, `digitOut`=0.
  - A subsequent correct code unlocks.
  - In OPEN, clear → `unlocked`=0.
- Reset mid-operation:
  - Pull `rstN` low during LOCKOUT → all outputs 0 asynchronously, state ENTRY.
- With COMBO_LOCK_PROG_EN:
  - Unlock, pulse prog, enter 5,6,7,8 → back in OPEN.
  - Relock: 1,2,3,4 fails; 5,6,7,8 unlocks.
